// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: address width, table sizes,
// and the 2-bit bimodal counter encodings with their saturating update.
package pc_gen_pkg;

    localparam int ADDR = 40;

    typedef logic [ADDR-1:0] addr_t;

    localparam addr_t DEFAULT_RESET_PC    = 40'h0;
    localparam int    DEFAULT_BHT_ENTRIES = 64;
    localparam int    DEFAULT_BTB_ENTRIES = 16;
    localparam addr_t INSN_BYTES          = 40'd4;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side and execute-side signals of the PC generator; the pipeline
// (master) drives the execute resolution, pc_gen (slave) drives fetch PC.
interface pc_gen_if;
    import pc_gen_pkg::*;

    logic  fetch_ready_i;
    logic  pc_valid_o;
    addr_t pc_o;
    logic  pred_taken_o;
    addr_t pred_target_o;
    logic  ex_valid_i;
    addr_t ex_pc_i;
    logic  ex_pred_taken_i;
    addr_t ex_pred_target_i;
    logic  branch_valid_i;
    logic  branch_taken_i;
    addr_t branch_target_i;
    addr_t branch_result_i;
    logic  mispredict_o;

    modport slave (
        input  fetch_ready_i, ex_valid_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i,
               branch_valid_i, branch_taken_i, branch_target_i, branch_result_i,
        output pc_valid_o, pc_o, pred_taken_o, pred_target_o, mispredict_o
    );

    modport master (
        output fetch_ready_i, ex_valid_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i,
               branch_valid_i, branch_taken_i, branch_target_i, branch_result_i,
        input  pc_valid_o, pc_o, pred_taken_o, pred_target_o, mispredict_o
    );

endinterface

// File: rtl/pc_gen_branch_predictor.sv
// Bimodal history table plus direct-mapped BTB: zero-cycle lookup on the
// fetch PC, update/alias-invalidate from the execute-stage resolution.
module branch_predictor import pc_gen_pkg::*; #(
    parameter int BHT_ENTRIES = DEFAULT_BHT_ENTRIES,
    parameter int BTB_ENTRIES = DEFAULT_BTB_ENTRIES
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t pc,
    input  logic  ex_valid,
    input  addr_t ex_pc,
    input  logic  ex_pred_taken,
    input  logic  branch_valid,
    input  logic  branch_taken,
    input  addr_t branch_target,
    output logic  taken,
    output addr_t target
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = ADDR - BTB_IDX_W - 2;

    ctr_e             bht_r        [BHT_ENTRIES];
    logic             btb_valid_r  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_r    [BTB_ENTRIES];
    addr_t            btb_target_r [BTB_ENTRIES];

    logic [BHT_IDX_W-1:0] look_bht_idx_s;
    logic [BHT_IDX_W-1:0] upd_bht_idx_s;
    logic [BTB_IDX_W-1:0] look_btb_idx_s;
    logic [BTB_IDX_W-1:0] upd_btb_idx_s;
    logic [TAG_W-1:0]     look_tag_s;
    logic [TAG_W-1:0]     upd_tag_s;
    logic [1:0]           look_ctr_s;
    logic                 upd_tag_match_s;
    logic                 unused_s;

    assign look_bht_idx_s = pc[BHT_IDX_W+1:2];
    assign look_btb_idx_s = pc[BTB_IDX_W+1:2];
    assign look_tag_s     = pc[ADDR-1:BTB_IDX_W+2];
    assign upd_bht_idx_s  = ex_pc[BHT_IDX_W+1:2];
    assign upd_btb_idx_s  = ex_pc[BTB_IDX_W+1:2];
    assign upd_tag_s      = ex_pc[ADDR-1:BTB_IDX_W+2];
    assign unused_s       = ^{pc[1:0], ex_pc[1:0]};

    assign upd_tag_match_s = btb_valid_r[upd_btb_idx_s] && (btb_tag_r[upd_btb_idx_s] == upd_tag_s);

    // Lookup: reads the pre-update table state, so a same-cycle write is seen next cycle
    always_comb begin
        look_ctr_s = bht_r[look_bht_idx_s];
        taken      = 1'b0;
        target     = btb_target_r[look_btb_idx_s];
        if (btb_valid_r[look_btb_idx_s] && (btb_tag_r[look_btb_idx_s] == look_tag_s)) begin
            taken = look_ctr_s[1];
        end else begin
            taken = 1'b0;
        end
    end

    // Table state: full clear on reset, train on branches, drop aliased entries
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_WNT;
            end
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_r[i]  <= 1'b0;
                btb_tag_r[i]    <= {TAG_W{1'b0}};
                btb_target_r[i] <= {ADDR{1'b0}};
            end
        end else if (ex_valid && branch_valid) begin
            bht_r[upd_bht_idx_s] <= ctr_update(bht_r[upd_bht_idx_s], branch_taken);
            if (branch_taken) begin
                btb_valid_r[upd_btb_idx_s]  <= 1'b1;
                btb_tag_r[upd_btb_idx_s]    <= upd_tag_s;
                btb_target_r[upd_btb_idx_s] <= branch_target;
            end
        end else if (ex_valid && ex_pred_taken && upd_tag_match_s) begin
            btb_valid_r[upd_btb_idx_s] <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC register, mispredict detection and next-PC mux.
// Define PC_GEN_BPRED_EN to add the bimodal/BTB next-PC predictor.
module pc_gen import pc_gen_pkg::*; #(
    parameter addr_t RESET_PC    = DEFAULT_RESET_PC,
    parameter int    BHT_ENTRIES = DEFAULT_BHT_ENTRIES,
    parameter int    BTB_ENTRIES = DEFAULT_BTB_ENTRIES
) (
    input logic     clk_i,
    input logic     rst_i,
    pc_gen_if.slave bus
);

    addr_t pc_r;
    logic  pc_valid_r;
    addr_t seq_pc_s;
    addr_t next_pc_s;
    logic  pred_taken_s;
    addr_t pred_target_s;
    logic  mispredict_s;

    assign seq_pc_s = pc_r + INSN_BYTES;

`ifdef PC_GEN_BPRED_EN
    addr_t btb_target_s;

    branch_predictor #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_bpred (
        .clk           (clk_i),
        .rst           (rst_i),
        .pc            (pc_r),
        .ex_valid      (bus.ex_valid_i),
        .ex_pc         (bus.ex_pc_i),
        .ex_pred_taken (bus.ex_pred_taken_i),
        .branch_valid  (bus.branch_valid_i),
        .branch_taken  (bus.branch_taken_i),
        .branch_target (bus.branch_target_i),
        .taken         (pred_taken_s),
        .target        (btb_target_s)
    );

    // Predicted next PC falls through to the sequential address on a not-taken guess
    always_comb begin
        pred_target_s = seq_pc_s;
        if (pred_taken_s) begin
            pred_target_s = btb_target_s;
        end else begin
            pred_target_s = seq_pc_s;
        end
    end

    // Wrong direction, or right direction but wrong taken target
    assign mispredict_s = bus.ex_valid_i &&
                          ((bus.branch_taken_i != bus.ex_pred_taken_i) ||
                           (bus.branch_taken_i && (bus.branch_target_i != bus.ex_pred_target_i)));
`else
    logic unused_s;
    localparam int unused_table_cfg = BHT_ENTRIES + BTB_ENTRIES;

    assign pred_taken_s  = 1'b0;
    assign pred_target_s = seq_pc_s;
    assign mispredict_s  = bus.ex_valid_i && bus.branch_taken_i;
    assign unused_s      = ^{bus.ex_pc_i, bus.ex_pred_taken_i, bus.ex_pred_target_i,
                             bus.branch_valid_i, bus.branch_target_i};
`endif

    // Next-PC priority: redirect beats fetch advance, which beats hold
    always_comb begin
        next_pc_s = pc_r;
        if (mispredict_s) begin
            next_pc_s = bus.branch_result_i;
        end else if (pc_valid_r && bus.fetch_ready_i) begin
            next_pc_s = pred_target_s;
        end else begin
            next_pc_s = pc_r;
        end
    end

    // PC register; reset overrides any pending redirect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r       <= RESET_PC;
            pc_valid_r <= 1'b0;
        end else begin
            pc_r       <= next_pc_s;
            pc_valid_r <= 1'b1;
        end
    end

    assign bus.pc_o          = pc_r;
    assign bus.pc_valid_o    = pc_valid_r;
    assign bus.pred_taken_o  = pred_taken_s;
    assign bus.pred_target_o = pred_target_s;
    assign bus.mispredict_o  = mispredict_s;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table plus hand-written redirect,
// wrap, training/alias (with PC_GEN_BPRED_EN) and mid-run reset sequences.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if bus ();

    pc_gen #(.RESET_PC(40'h10_00)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    addr_t exp_q[$];
    addr_t model_pc;

    typedef struct {
        logic  ready;
        logic  ex_valid;
        addr_t ex_pc;
        logic  ex_pt;
        addr_t ex_ptgt;
        logic  bv;
        logic  bt;
        addr_t btgt;
        addr_t bres;
        logic  exp_mp;
        addr_t exp_next;
    } vec_t;

    vec_t vecs[13];

    task automatic chk_addr(input string nm, input addr_t act, input addr_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ready, input logic exv, input addr_t expc,
                         input logic ept, input addr_t eptgt, input logic bv,
                         input logic bt, input addr_t btgt, input addr_t bres);
        bus.fetch_ready_i    = ready;
        bus.ex_valid_i       = exv;
        bus.ex_pc_i          = expc;
        bus.ex_pred_taken_i  = ept;
        bus.ex_pred_target_i = eptgt;
        bus.branch_valid_i   = bv;
        bus.branch_taken_i   = bt;
        bus.branch_target_i  = btgt;
        bus.branch_result_i  = bres;
    endtask

    // One cycle: drive, check combinational outputs, push expected PC, clock, pop and compare
    task automatic step(input logic ready, input logic exv, input addr_t expc,
                        input logic ept, input addr_t eptgt, input logic bv,
                        input logic bt, input addr_t btgt, input addr_t bres,
                        input logic exp_mp, input addr_t exp_next,
                        input logic exp_pt, input addr_t exp_ptgt, input string tag);
        addr_t e;
        drive(ready, exv, expc, ept, eptgt, bv, bt, btgt, bres);
        #2;
        chk_bit($sformatf("%s mispredict", tag), bus.mispredict_o, exp_mp);
        chk_bit($sformatf("%s pred_taken", tag), bus.pred_taken_o, exp_pt);
        chk_addr($sformatf("%s pred_target", tag), bus.pred_target_o, exp_ptgt);
        exp_q.push_back(exp_next);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_addr($sformatf("%s pc", tag), bus.pc_o, e);
        chk_bit($sformatf("%s pc_valid", tag), bus.pc_valid_o, 1'b1);
        model_pc = e;
    endtask

    task automatic idle(input logic ready, input addr_t exp_next, input logic exp_pt,
                        input addr_t exp_ptgt, input string tag);
        step(ready, 1'b0, 40'h0, 1'b0, 40'h0, 1'b0, 1'b0, 40'h0, 40'h0,
             1'b0, exp_next, exp_pt, exp_ptgt, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 40'h0, 1'b0, 40'h0, 1'b0, 1'b0, 40'h0, 40'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_bit("reset pc_valid", bus.pc_valid_o, 1'b0);
            chk_addr("reset pc", bus.pc_o, 40'h10_00);
            chk_bit("reset pred_taken", bus.pred_taken_o, 1'b0);
            chk_addr("reset pred_target", bus.pred_target_o, 40'h10_04);
            chk_bit("reset mispredict", bus.mispredict_o, 1'b0);
        end
        rst = 1'b0;
        model_pc = 40'h10_00;

        // ready, exv, ex_pc, ex_pt, ex_ptgt, bv, bt, btgt, bres, exp_mp, exp_next
        vecs[0]  = '{1'b1, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h1000};
        vecs[1]  = '{1'b1, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h1004};
        vecs[2]  = '{1'b1, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h1008};
        vecs[3]  = '{1'b0, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h1008};
        vecs[4]  = '{1'b0, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h1008};
        vecs[5]  = '{1'b0, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h1008};
        vecs[6]  = '{1'b0, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h1008};
        vecs[7]  = '{1'b0, 1'b1, 40'h1000, 1'b0, 40'h1004, 1'b1, 1'b1, 40'h2000, 40'h2000, 1'b1, 40'h2000};
        vecs[8]  = '{1'b1, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h2004};
        vecs[9]  = '{1'b1, 1'b1, 40'h2000, 1'b0, 40'h2004, 1'b0, 1'b0, 40'h0,    40'h2004, 1'b0, 40'h2008};
        vecs[10] = '{1'b1, 1'b1, 40'h3010, 1'b0, 40'h3014, 1'b1, 1'b0, 40'h3100, 40'h3014, 1'b0, 40'h200C};
        vecs[11] = '{1'b0, 1'b1, 40'h2008, 1'b0, 40'h200C, 1'b1, 1'b1, 40'h2100, 40'h2100, 1'b1, 40'h2100};
        vecs[12] = '{1'b1, 1'b0, 40'h0,    1'b0, 40'h0,    1'b0, 1'b0, 40'h0,    40'h0,    1'b0, 40'h2104};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].ready, vecs[i].ex_valid, vecs[i].ex_pc, vecs[i].ex_pt, vecs[i].ex_ptgt,
                 vecs[i].bv, vecs[i].bt, vecs[i].btgt, vecs[i].bres, vecs[i].exp_mp,
                 vecs[i].exp_next, 1'b0, model_pc + 40'd4, $sformatf("vec%0d", i));
        end

        // Wrap-around of the 40-bit PC
        step(1'b1, 1'b1, 40'h4020, 1'b0, 40'h4024, 1'b1, 1'b1, 40'hFF_FFFF_FFFC, 40'hFF_FFFF_FFFC,
             1'b1, 40'hFF_FFFF_FFFC, 1'b0, 40'h2108, "wrap_redirect");
        idle(1'b1, 40'h0, 1'b0, 40'h0, "wrap_advance");
        idle(1'b1, 40'h4, 1'b0, 40'h4, "wrap_next");

`ifdef PC_GEN_BPRED_EN
        step(1'b0, 1'b1, 40'h1000, 1'b0, 40'h1004, 1'b1, 1'b1, 40'h2000, 40'h2000,
             1'b1, 40'h2000, 1'b0, 40'h8, "train1");
        step(1'b0, 1'b1, 40'h1000, 1'b0, 40'h1004, 1'b1, 1'b1, 40'h2000, 40'h2000,
             1'b1, 40'h2000, 1'b0, 40'h2004, "train2");
        step(1'b0, 1'b1, 40'h5010, 1'b0, 40'h5014, 1'b1, 1'b1, 40'h1000, 40'h1000,
             1'b1, 40'h1000, 1'b0, 40'h2004, "to_1000");
        idle(1'b1, 40'h2000, 1'b1, 40'h2000, "predict_taken");
        step(1'b0, 1'b1, 40'h1000, 1'b1, 40'h2000, 1'b1, 1'b1, 40'h2000, 40'h2000,
             1'b0, 40'h2000, 1'b0, 40'h2004, "taken_match");
        step(1'b0, 1'b1, 40'h3010, 1'b0, 40'h3014, 1'b1, 1'b0, 40'h3100, 40'h3014,
             1'b0, 40'h2000, 1'b0, 40'h2004, "nt_match");
        step(1'b0, 1'b1, 40'h1000, 1'b1, 40'h2000, 1'b0, 1'b0, 40'h0, 40'h1004,
             1'b1, 40'h1004, 1'b0, 40'h2004, "alias");
        step(1'b0, 1'b1, 40'h5010, 1'b0, 40'h5014, 1'b1, 1'b1, 40'h1000, 40'h1000,
             1'b1, 40'h1000, 1'b0, 40'h1008, "back_to_1000");
        idle(1'b1, 40'h1004, 1'b0, 40'h1004, "alias_invalidated");
        step(1'b1, 1'b1, 40'h1000, 1'b0, 40'h1004, 1'b1, 1'b1, 40'h2000, 40'h2000,
             1'b1, 40'h2000, 1'b0, 40'h1008, "retrain");
`endif

        // Reset during a pending redirect wins and clears the tables
        drive(1'b1, 1'b1, 40'h1000, 1'b0, 40'h1004, 1'b1, 1'b1, 40'h3000, 40'h3000);
        rst = 1'b1;
        #2;
        chk_bit("midreset mispredict", bus.mispredict_o, 1'b1);
        @(posedge clk);
        #1;
        chk_addr("midreset pc", bus.pc_o, 40'h1000);
        chk_bit("midreset pc_valid", bus.pc_valid_o, 1'b0);
        drive(1'b1, 1'b0, 40'h0, 1'b0, 40'h0, 1'b0, 1'b0, 40'h0, 40'h0);
        #2;
        chk_bit("midreset pred_taken", bus.pred_taken_o, 1'b0);
        chk_addr("midreset pred_target", bus.pred_target_o, 40'h1004);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b1, 40'h1000, 1'b0, 40'h1004, "release");
        idle(1'b1, 40'h1004, 1'b0, 40'h1004, "release_adv");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
